// File: rtl/ps2_scancode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_scancode_pkg                                            |
// | Brief  : PS/2 set-2 scancode constants, parser states, key width fn  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package ps2_scancode_pkg;

  // Protocol prefix / status bytes
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BAT   = 8'hAA;

  // Make codes of the default game keys
  localparam logic [7:0] PS2_KEY_Z = 8'h1A;
  localparam logic [7:0] PS2_KEY_X = 8'h22;
  localparam logic [7:0] PS2_KEY_C = 8'h21;
  localparam logic [7:0] PS2_KEY_V = 8'h2A;
  localparam logic [7:0] PS2_KEY_B = 8'h32;

  // Byte-sequence parser states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } parser_state_e;

  // Width of a key index; never below one bit so a single key still has a port
  function automatic int key_index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : key_event_fifo                                              |
// | Brief  : Registered event queue, count-based full/empty, sticky      |
// |          overflow flag; no write-to-read bypass                       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module key_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  // A pop frees a slot in the same cycle, so a push into a full queue still lands
  assign w_do_pop  = pop & ~w_empty;
  assign w_do_push = push & (~w_full | w_do_pop);

  // Storage write; contents need no reset because the output is gated by empty
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (push & ~w_do_push) r_overflow <= 1'b1;
    end
  end

  assign valid    = ~w_empty;
  assign pop_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/ps2_key_event_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_key_event_decoder                                       |
// | Brief  : PS/2 byte-stream parser, held-key mask, typematic filter,   |
// |          make/break event queue and legacy priority code             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ps2_key_event_decoder
  import ps2_scancode_pkg::*;
#(
  parameter int                  NUM_KEYS   = 5,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES = {PS2_KEY_B, PS2_KEY_V, PS2_KEY_C,
                                                PS2_KEY_X, PS2_KEY_Z},
  parameter int                  FIFO_DEPTH = 4,
  localparam int                 KEY_W      = key_index_width(NUM_KEYS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                any_held,
  output logic [KEY_W:0]      priority_code,
  output logic                evt_valid,
  output logic [KEY_W-1:0]    evt_key,
  output logic                evt_make,
  input  logic                evt_ready,
  output logic                overflow
);

  parser_state_e       r_state;
  parser_state_e       w_state_next;
  logic [NUM_KEYS-1:0] r_key_held;
  logic [NUM_KEYS-1:0] w_held_next;
  logic                w_match;
  logic [KEY_W-1:0]    w_match_idx;
  logic                w_do_make;
  logic                w_do_break;
  logic                w_push;
  logic                w_push_make;
  logic [KEY_W:0]      w_prio;
  logic [KEY_W:0]      w_evt_data;

  // Map the incoming byte to the lowest key index carrying that make code
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[8*i +: 8] == rx_data) begin
        w_match     = 1'b1;
        w_match_idx = KEY_W'(i);
      end
    end
  end

  // Parser state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Parser next state; extended sequences are consumed but never mapped
  always_comb begin
    w_state_next = r_state;
    w_do_make    = 1'b0;
    w_do_break   = 1'b0;
    if (rx_valid) begin
      case (r_state)
        IDLE: begin
          if (rx_data == PS2_EXT)        w_state_next = EXT;
          else if (rx_data == PS2_BREAK) w_state_next = BRK;
          else                           w_do_make    = 1'b1;
        end
        EXT: begin
          if (rx_data == PS2_BREAK) w_state_next = EXT_BRK;
          else                      w_state_next = IDLE;
        end
        BRK: begin
          w_do_break   = 1'b1;
          w_state_next = IDLE;
        end
        EXT_BRK: w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Held-mask update and event generation; repeats and stray breaks are silent
  always_comb begin
    w_held_next = r_key_held;
    w_push      = 1'b0;
    w_push_make = 1'b0;
    if (w_do_make && w_match && !r_key_held[w_match_idx]) begin
      w_held_next[w_match_idx] = 1'b1;
      w_push                   = 1'b1;
      w_push_make              = 1'b1;
    end else if (w_do_break && w_match && r_key_held[w_match_idx]) begin
      w_held_next[w_match_idx] = 1'b0;
      w_push                   = 1'b1;
    end
  end

  // Held-mask register; updates even when the event queue drops the event
  always_ff @(posedge clock) begin
    if (reset) r_key_held <= '0;
    else       r_key_held <= w_held_next;
  end

  // Legacy priority code: lowest held index plus one, zero when idle
  always_comb begin
    w_prio = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (r_key_held[i]) w_prio = (KEY_W+1)'(i + 1);
    end
  end

  key_event_fifo #(
    .WIDTH (KEY_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data ({w_match_idx, w_push_make}),
    .pop       (evt_ready),
    .pop_data  (w_evt_data),
    .valid     (evt_valid),
    .overflow  (overflow)
  );

  assign key_held      = r_key_held;
  assign any_held      = |r_key_held;
  assign priority_code = w_prio;
  assign evt_key       = w_evt_data[KEY_W:1];
  assign evt_make      = w_evt_data[0];

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_ps2_key_event_decoder                                    |
// | Brief  : Self-checking bench with a queue-based reference model      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_ps2_key_event_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [4:0] key_held;
  logic       any_held;
  logic [3:0] priority_code;
  logic       evt_valid;
  logic [2:0] evt_key;
  logic       evt_make;
  logic       evt_ready = 1'b0;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_key_event_decoder dut (
    .clock         (clock),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .key_held      (key_held),
    .any_held      (any_held),
    .priority_code (priority_code),
    .evt_valid     (evt_valid),
    .evt_key       (evt_key),
    .evt_make      (evt_make),
    .evt_ready     (evt_ready),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  // Reference model: held mask, bounded event queue, pending prefix bytes
  logic [7:0] codes [5] = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32};
  logic [4:0] m_held;
  logic [3:0] m_q [$];
  bit         m_ovf;
  logic [7:0] m_pend [$];
  logic [3:0] obs_pops [$];
  logic [3:0] exp_pops [$];

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < 5; i++) if (codes[i] == b) return i;
    return -1;
  endfunction

  function automatic void enqueue(input logic [3:0] e);
    if (m_q.size() < 4) m_q.push_back(e);
    else                m_ovf = 1'b1;
  endfunction

  function automatic void key_action(input int k, input bit make);
    if (k < 0) return;
    if (make && !m_held[k]) begin
      m_held[k] = 1'b1;
      enqueue({3'(k), 1'b1});
    end else if (!make && m_held[k]) begin
      m_held[k] = 1'b0;
      enqueue({3'(k), 1'b0});
    end
  endfunction

  // A sequence is complete once it is not a bare prefix (E0, F0, E0 F0)
  function automatic void model_byte(input logic [7:0] b);
    m_pend.push_back(b);
    if (m_pend.size() == 1 && (b == 8'hE0 || b == 8'hF0)) return;
    if (m_pend.size() == 2 && m_pend[0] == 8'hE0 && b == 8'hF0) return;
    if (m_pend[0] == 8'hE0)      ;
    else if (m_pend[0] == 8'hF0) key_action(lookup(m_pend[1]), 1'b0);
    else                         key_action(lookup(m_pend[0]), 1'b1);
    m_pend.delete();
  endfunction

  function automatic logic [3:0] ref_prio(input logic [4:0] h);
    for (int i = 0; i < 5; i++) if (h[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b0; evt_ready = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_held = '0; m_q.delete(); m_ovf = 1'b0; m_pend.delete();
    obs_pops.delete(); exp_pops.delete();
  endtask

  // One clock cycle of stimulus; records DUT and model pops for later comparison
  task automatic step(input logic v, input logic [7:0] b, input logic rdy);
    rx_valid  = v;
    rx_data   = v ? b : 8'($urandom);
    evt_ready = rdy;
    if (rdy && evt_valid)        obs_pops.push_back({evt_key, evt_make});
    if (rdy && m_q.size() > 0)   exp_pops.push_back(m_q.pop_front());
    if (v) model_byte(b);
    @(posedge clock); #1;
    rx_valid  = 1'b0;
    evt_ready = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({key_held, any_held, priority_code, evt_valid, evt_key, evt_make, overflow} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got held=%b any=%b prio=%0d ev=%b key=%0d mk=%b ovf=%b required all zero",
               key_held, any_held, priority_code, evt_valid, evt_key, evt_make, overflow);
    end
  endtask

  task automatic test_single_make();
    do_reset();
    step(1'b1, 8'h1A, 1'b0);
    n_tests++;
    if (key_held !== 5'b00001 || priority_code !== 4'd1 || any_held !== 1'b1) begin
      n_fail++;
      $display("FAIL single_held: got held=%b prio=%0d any=%b required 00001/1/1", key_held, priority_code, any_held);
    end
    n_tests++;
    if (evt_valid !== 1'b1 || evt_key !== 3'd0 || evt_make !== 1'b1) begin
      n_fail++;
      $display("FAIL single_event: got v=%b key=%0d mk=%b required 1/0/1", evt_valid, evt_key, evt_make);
    end
    step(1'b0, 8'h00, 1'b1);
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: got evt_valid=%b required 0", evt_valid);
    end
  endtask

  task automatic test_typematic();
    do_reset();
    step(1'b1, 8'h22, 1'b0); step(1'b1, 8'h22, 1'b0); step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'hF0, 1'b0); step(1'b1, 8'h22, 1'b0);
    n_tests++;
    if (key_held !== m_held) begin
      n_fail++;
      $display("FAIL typematic_held: got %b required %b", key_held, m_held);
    end
    drain(4);
    n_tests++;
    if (obs_pops.size() != 2 || obs_pops.size() != exp_pops.size()) begin
      n_fail++;
      $display("FAIL typematic_count: got %0d events required %0d", obs_pops.size(), exp_pops.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (obs_pops[i] !== exp_pops[i]) begin
          n_fail++;
          $display("FAIL typematic_event%0d: got %h required %h", i, obs_pops[i], exp_pops[i]);
        end
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    step(1'b1, 8'h1A, 1'b1); step(1'b1, 8'h32, 1'b1);
    n_tests++;
    if (key_held !== 5'b10001 || priority_code !== 4'd1) begin
      n_fail++;
      $display("FAIL prio_two_held: got held=%b prio=%0d required 10001/1", key_held, priority_code);
    end
    step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h1A, 1'b1);
    n_tests++;
    if (priority_code !== 4'd5 || priority_code !== ref_prio(m_held)) begin
      n_fail++;
      $display("FAIL prio_after_release: got %0d required %0d", priority_code, ref_prio(m_held));
    end
  endtask

  task automatic test_extended();
    do_reset();
    step(1'b1, 8'h22, 1'b1);
    drain(2);
    step(1'b1, 8'hE0, 1'b1); step(1'b1, 8'h1A, 1'b1);
    step(1'b1, 8'hE0, 1'b1); step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h22, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    n_tests++;
    if (key_held !== 5'b00010 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL extended_ignored: got held=%b ev=%b required 00010/0", key_held, evt_valid);
    end
    step(1'b1, 8'h21, 1'b0);
    n_tests++;
    if (key_held !== 5'b00110 || evt_key !== 3'd2 || evt_make !== 1'b1) begin
      n_fail++;
      $display("FAIL extended_resume: got held=%b key=%0d mk=%b required 00110/2/1", key_held, evt_key, evt_make);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    step(1'b1, 8'h1A, 1'b0); step(1'b1, 8'h22, 1'b0); step(1'b1, 8'h21, 1'b0);
    step(1'b1, 8'h2A, 1'b0); step(1'b1, 8'h32, 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || key_held !== 5'b11111) begin
      n_fail++;
      $display("FAIL overflow_set: got ovf=%b held=%b required 1/11111", overflow, key_held);
    end
    drain(6);
    n_tests++;
    if (obs_pops.size() != 4 || exp_pops.size() != 4) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d events required 4", obs_pops.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (obs_pops[i] !== exp_pops[i]) begin
          n_fail++;
          $display("FAIL overflow_order%0d: got %h required %h", i, obs_pops[i], exp_pops[i]);
        end
      end
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %b required 1", overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 8'h1A, 1'b0); step(1'b1, 8'h22, 1'b0); step(1'b1, 8'h21, 1'b0);
    step(1'b1, 8'h2A, 1'b0); step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h1A, 1'b1);
    n_tests++;
    if (overflow !== 1'b0 || key_held !== 5'b01110) begin
      n_fail++;
      $display("FAIL full_push_pop: got ovf=%b held=%b required 0/01110", overflow, key_held);
    end
    drain(6);
    n_tests++;
    if (obs_pops.size() != 5 || exp_pops.size() != 5) begin
      n_fail++;
      $display("FAIL full_push_pop_count: got %0d events required 5", obs_pops.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (obs_pops[i] !== exp_pops[i]) begin
          n_fail++;
          $display("FAIL full_push_pop_event%0d: got %h required %h", i, obs_pops[i], exp_pops[i]);
        end
      end
    end
    // Empty queue: push and pop together must store without bypass
    step(1'b1, 8'h32, 1'b1);
    n_tests++;
    if (evt_valid !== 1'b1 || evt_key !== 3'd4 || evt_make !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_push_pop: got v=%b key=%0d mk=%b required 1/4/1", evt_valid, evt_key, evt_make);
    end
  endtask

  task automatic test_reset_mid_sequence();
    do_reset();
    step(1'b1, 8'hF0, 1'b0);
    do_reset();
    step(1'b1, 8'h1A, 1'b0);
    n_tests++;
    if (key_held !== 5'b00001 || evt_make !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_seq: got held=%b mk=%b required 00001/1", key_held, evt_make);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)       b = codes[r];
      else if (r == 5) b = 8'hE0;
      else if (r == 6) b = 8'hF0;
      else if (r == 7) b = 8'hAA;
      else if (r == 8) b = 8'h5A;
      else             b = 8'($urandom);
      step(1'($urandom_range(0, 1)), b, ($urandom_range(0, 2) == 0));
      n_tests++;
      if (key_held !== m_held || any_held !== (|m_held) || priority_code !== ref_prio(m_held)) begin
        n_fail++;
        $display("FAIL rand_held c=%0d: got held=%b any=%b prio=%0d required %b/%b/%0d",
                 c, key_held, any_held, priority_code, m_held, |m_held, ref_prio(m_held));
      end
      n_tests++;
      if (evt_valid !== (m_q.size() > 0) || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_status c=%0d: got ev=%b ovf=%b required %b/%b",
                 c, evt_valid, overflow, m_q.size() > 0, m_ovf);
      end
      if (m_q.size() > 0) begin
        n_tests++;
        if ({evt_key, evt_make} !== m_q[0]) begin
          n_fail++;
          $display("FAIL rand_head c=%0d: got %h required %h", c, {evt_key, evt_make}, m_q[0]);
        end
      end
    end
    n_tests++;
    if (obs_pops != exp_pops) begin
      n_fail++;
      $display("FAIL rand_pops: got %0d popped events required %0d (or content differs)",
               obs_pops.size(), exp_pops.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_typematic();
    test_priority();
    test_extended();
    test_overflow();
    test_back_to_back();
    test_reset_mid_sequence();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
